// File: rtl/uart_word_tx.sv
// Word-wide UART 8N1 transmitter: sends NUM_BYTES bytes back-to-back, LSB byte first,
// LSB bit first, on a registered glitch-free line.
module uart_word_tx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [8*NUM_BYTES-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned DATA_W       = 8 * NUM_BYTES;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud_cnt, baud_n;
  logic [2:0]          bit_cnt, bit_n;
  logic [BYTE_W-1:0]   byte_cnt, byte_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                tx_q, tx_n;
  logic                done_q, done_n;
  logic                baud_last;

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  // Line level is computed from the next state so o_tx changes on the same edge as the state.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    shreg_n = shreg;
    tx_n    = 1'b1;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          shreg_n = i_data;
          byte_n  = '0;
          bit_n   = '0;
          baud_n  = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (baud_last) begin
          baud_n  = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (baud_last) begin
          baud_n  = '0;
          shreg_n = {1'b0, shreg[DATA_W-1:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n = shreg[1];
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_last) begin
          baud_n = '0;
          if (byte_cnt == BYTE_W'(NUM_BYTES - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            byte_n  = byte_cnt + BYTE_W'(1);
            state_n = START;
            tx_n    = 1'b0;
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
    endcase
  end

  assign o_tx    = tx_q;
  assign o_done  = done_q;
  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench: stimulus queues expected words; a mid-bit-sampling UART receiver
// reassembles words from the line and checks them against the queue.
module tb_uart_word_tx;

  localparam int CPB      = 16;
  localparam int NB       = 4;
  localparam int WORD_CYC = 10 * NB * CPB;

  logic        tb_clk  = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_data  = '0;
  logic        o_ready, o_tx, o_busy, o_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];

  uart_word_tx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1),
    .NUM_BYTES(NB)
  ) dut (
    .i_clk  (tb_clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_tx   (o_tx),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver model: detect a falling edge, then sample each bit at its centre.
  logic        rx_on   = 1'b0;
  logic        prev_tx = 1'b1;
  int          rx_n    = 0;
  int          rx_idx  = 0;
  logic [7:0]  rx_byte = '0;
  logic [31:0] rx_word = '0;

  initial begin
    forever begin
      @(negedge tb_clk);
      if (i_reset) begin
        rx_on   = 1'b0;
        rx_n    = 0;
        rx_idx  = 0;
        rx_word = '0;
        prev_tx = 1'b1;
      end else begin
        if (!rx_on) begin
          if (prev_tx && !o_tx) begin
            rx_on = 1'b1;
            rx_n  = 0;
          end
        end else begin
          rx_n++;
          if (rx_n % CPB == CPB / 2) begin
            if (rx_n / CPB == 0) begin
              check("start_bit", {31'd0, o_tx}, 32'd0);
            end else if (rx_n / CPB <= 8) begin
              rx_byte[rx_n / CPB - 1] = o_tx;
            end else begin
              check("stop_bit", {31'd0, o_tx}, 32'd1);
              rx_word = rx_word | (32'(rx_byte) << (8 * rx_idx));
              rx_idx++;
              rx_on = 1'b0;
              if (rx_idx == NB) begin
                if (exp_q.size() == 0) begin
                  check("unexpected_word", rx_word, 32'hxxxxxxxx);
                end else begin
                  check("rx_word", rx_word, exp_q.pop_front());
                end
                rx_idx  = 0;
                rx_word = '0;
              end
            end
          end
        end
        prev_tx = o_tx;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [31:0] d, output int c0);
    int w;
    w       = 0;
    i_data  = d;
    i_valid = 1'b1;
    while (!o_ready && w < 2 * WORD_CYC) begin
      @(negedge tb_clk);
      w++;
    end
    if (!o_ready) check("ready_timeout", {31'd0, o_ready}, 32'd1);
    exp_q.push_back(d);
    @(negedge tb_clk);
    c0 = cyc;
    check("tx_fall_latency", {31'd0, o_tx}, 32'd0);
    check("busy_after_accept", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic wait_done(output int dc);
    int w;
    w = 0;
    do begin
      @(negedge tb_clk);
      w++;
    end while (!o_done && w < 2 * WORD_CYC);
    check("done_seen", {31'd0, o_done}, 32'd1);
    check("ready_in_done", {31'd0, o_ready}, 32'd1);
    dc = cyc;
  endtask

  int c0, dc, bad;
  logic [31:0] w;

  initial begin
    // 1. reset
    repeat (5) @(negedge tb_clk);
    check("rst_tx", {31'd0, o_tx}, 32'd1);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    i_reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge tb_clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
    end
    check("idle_no_activity", 32'(bad), 32'd0);

    // 2. "mol\0", timing and single-cycle done
    issue(32'h006C6F6D, c0);
    i_valid = 1'b0;
    i_data  = $urandom;
    wait_done(dc);
    check("word_length", 32'(dc - c0), 32'(WORD_CYC));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge tb_clk);
    check("done_one_cycle", {31'd0, o_done}, 32'd0);
    check("tx_idle_after", {31'd0, o_tx}, 32'd1);

    // 3. valid held: second word starts straight out of the done cycle
    issue(32'h00000002, c0);
    wait_done(dc);
    check("word_length_held", 32'(dc - c0), 32'(WORD_CYC));
    exp_q.push_back(32'h00000002);
    @(negedge tb_clk);
    i_valid = 1'b0;
    check("b2b_start_cycle", 32'(cyc), 32'(dc + 1));
    check("b2b_start_low", {31'd0, o_tx}, 32'd0);
    c0 = cyc;
    wait_done(dc);
    check("word_length_b2b", 32'(dc - c0), 32'(WORD_CYC));
    check("queue_drained_b2b", 32'(exp_q.size()), 32'd0);

    // 4. data churn and valid pulses while busy
    issue($urandom, c0);
    i_valid = 1'b0;
    for (int p = 0; p < 5; p++) begin
      repeat ($urandom_range(10, 80)) @(negedge tb_clk);
      i_data  = $urandom;
      i_valid = 1'b1;
      check("ready_low_busy", {31'd0, o_ready}, 32'd0);
      @(negedge tb_clk);
      i_valid = 1'b0;
    end
    wait_done(dc);
    check("word_length_churn", 32'(dc - c0), 32'(WORD_CYC));
    check("queue_drained_churn", 32'(exp_q.size()), 32'd0);

    // 5. reset in the middle of byte 2 DATA
    issue(32'hA5C3_0FF0, c0);
    i_valid = 1'b0;
    repeat (345 - 1) @(negedge tb_clk);
    #2 i_reset = 1'b1;
    #1;
    check("midrst_tx", {31'd0, o_tx}, 32'd1);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_ready", {31'd0, o_ready}, 32'd1);
    void'(exp_q.pop_back());
    repeat (3) @(negedge tb_clk);
    i_reset = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge tb_clk);
      if (o_done !== 1'b0 || o_tx !== 1'b1) bad++;
    end
    check("midrst_quiet", 32'(bad), 32'd0);
    issue(32'h1234_5678, c0);
    i_valid = 1'b0;
    wait_done(dc);
    check("word_length_postrst", 32'(dc - c0), 32'(WORD_CYC));
    check("queue_drained_postrst", 32'(exp_q.size()), 32'd0);

    // 6. loopback patterns
    issue(32'hFFFFFFFF, c0);
    i_valid = 1'b0;
    wait_done(dc);
    issue(32'h80000001, c0);
    i_valid = 1'b0;
    wait_done(dc);
    check("queue_drained_loop", 32'(exp_q.size()), 32'd0);

    // random words with random idle gaps
    for (int r = 0; r < 6; r++) begin
      w = $urandom;
      issue(w, c0);
      i_valid = 1'b0;
      i_data  = ~w;
      wait_done(dc);
      check("word_length_rand", 32'(dc - c0), 32'(WORD_CYC));
      repeat ($urandom_range(0, 5)) @(negedge tb_clk);
    end
    repeat (20) @(negedge tb_clk);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
